// File: rtl/sa_psum_collector.sv
// ============================================================================
// Module   : sa_psum_collector
// Brief    : De-skews systolic-array row psum streams into aligned output
//            vectors and counts them against a programmed total.
//            Define PSUM_RELU_EN to clamp negative lanes to zero at load.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sa_psum_collector #(
  parameter int PE_SIZE    = 16,
  parameter int PSUM_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic [CNT_W-1:0]              num_vec_i,
  input  logic [PSUM_WIDTH*PE_SIZE-1:0] psum_row_i,
  input  logic [PE_SIZE-1:0]            psum_en_row_i,
  output logic [PSUM_WIDTH*PE_SIZE-1:0] out_data_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          overflow_o
);

  localparam int c_addr_w = $clog2(DEPTH);
  localparam int c_vec_w  = PSUM_WIDTH * PE_SIZE;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_num_vec;
  logic [c_vec_w-1:0] r_out_data;
  logic [c_vec_w-1:0] w_head;
  logic               r_out_valid;
  logic               r_overflow;
  logic [PE_SIZE-1:0] w_empty;
  logic [PE_SIZE-1:0] w_drop;
  logic               w_collect;
  logic               w_start;
  logic               w_hs;
  logic               w_load;
  logic               w_last;
  logic [CNT_W:0]     w_issued;

  assign w_collect = (r_state == ST_COLLECT);
  assign w_start   = start_i && (r_state == ST_IDLE);
  assign w_hs      = w_collect && r_out_valid && out_ready_i;
  // Vectors already emitted plus the one sitting in the output register
  assign w_issued  = {1'b0, r_cnt} + {{CNT_W{1'b0}}, r_out_valid};
  assign w_load    = w_collect && ~|w_empty && (!r_out_valid || out_ready_i)
                     && (w_issued < {1'b0, r_num_vec});
  assign w_last    = w_hs && ((r_cnt + CNT_W'(1)) == r_num_vec);

  for (genvar gi = 0; gi < PE_SIZE; gi++) begin : g_lane
    logic [PSUM_WIDTH-1:0] r_mem [DEPTH];
    logic [c_addr_w:0]     r_wr_ptr;
    logic [c_addr_w:0]     r_rd_ptr;
    logic [PSUM_WIDTH-1:0] w_in;
    logic [PSUM_WIDTH-1:0] w_rd_data;
    logic                  w_en;
    logic                  w_full;
    logic                  w_wr;

    assign w_in         = psum_row_i[PSUM_WIDTH*(PE_SIZE-1-gi) +: PSUM_WIDTH];
    assign w_en         = w_collect && psum_en_row_i[gi];
    assign w_empty[gi]  = (r_wr_ptr == r_rd_ptr);
    assign w_full       = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w])
                          && (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts
    assign w_wr         = w_en && (!w_full || w_load);
    assign w_drop[gi]   = w_en && w_full && !w_load;
    assign w_rd_data    = r_mem[r_rd_ptr[c_addr_w-1:0]];

`ifdef PSUM_RELU_EN
    assign w_head[PSUM_WIDTH*(PE_SIZE-1-gi) +: PSUM_WIDTH] =
      w_rd_data[PSUM_WIDTH-1] ? '0 : w_rd_data;
`else
    assign w_head[PSUM_WIDTH*(PE_SIZE-1-gi) +: PSUM_WIDTH] = w_rd_data;
`endif

    always_ff @(posedge clk) begin
      if (w_wr) begin
        r_mem[r_wr_ptr[c_addr_w-1:0]] <= w_in;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else if (w_start) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_load) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_start) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_data  <= w_head;
      r_out_valid <= 1'b1;
    end else if (w_hs) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_num_vec  <= '0;
      r_overflow <= 1'b0;
    end else if (w_start) begin
      r_cnt      <= '0;
      r_num_vec  <= num_vec_i;
      r_overflow <= 1'b0;
    end else begin
      if (w_hs) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (|w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_state_nxt = (num_vec_i == '0) ? ST_DONE : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign out_data_o  = r_out_data;
  assign out_valid_o = r_out_valid;
  assign busy_o      = w_collect;
  assign done_o      = (r_state == ST_DONE);
  assign overflow_o  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_sa_psum_collector.sv
// ============================================================================
// Module   : tb_sa_psum_collector
// Brief    : Scoreboard bench for sa_psum_collector (aligned, skewed,
//            backpressure, overflow, zero/abort and lane clamp scenarios).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sa_psum_collector;
  localparam int P  = 16;
  localparam int W  = 32;
  localparam int D  = 16;
  localparam int CW = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start_i = 1'b0;
  logic [CW-1:0]  num_vec_i = '0;
  logic [P*W-1:0] psum_row_i = '0;
  logic [P-1:0]   psum_en_row_i = '0;
  logic [P*W-1:0] out_data_o;
  logic           out_valid_o;
  logic           out_ready_i = 1'b1;
  logic           busy_o;
  logic           done_o;
  logic           overflow_o;

  int checks = 0;
  int errors = 0;
  logic [P*W-1:0] sb[$];

  always #5 clk = ~clk;

  sa_psum_collector #(
    .PE_SIZE(P), .PSUM_WIDTH(W), .DEPTH(D), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .num_vec_i(num_vec_i),
    .psum_row_i(psum_row_i), .psum_en_row_i(psum_en_row_i),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .busy_o(busy_o), .done_o(done_o),
    .overflow_o(overflow_o)
  );

  task automatic do_start(input int n);
    start_i   = 1'b1;
    num_vec_i = CW'(n);
    @(posedge clk); #1;
    start_i   = 1'b0;
  endtask

  // Lane i writes mult*k+i at cycle k+skew*i; a vector is expected once its last lane is written
  task automatic drive_stream(input int nvec, input int mult, input int skew);
    logic [P*W-1:0] v;
    for (int c = 0; c < nvec + skew*(P-1); c++) begin
      psum_en_row_i = '0;
      for (int i = 0; i < P; i++) begin
        int k;
        k = c - skew*i;
        if (k >= 0 && k < nvec) begin
          psum_en_row_i[i] = 1'b1;
          psum_row_i[W*(P-1-i) +: W] = W'(mult*k + i);
        end
      end
      if (c - skew*(P-1) >= 0) begin
        v = '0;
        for (int i = 0; i < P; i++) v[W*(P-1-i) +: W] = W'(mult*(c - skew*(P-1)) + i);
        sb.push_back(v);
      end
      @(posedge clk); #1;
    end
    psum_en_row_i = '0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (out_data_o !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", out_data_o); end
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid_o); end
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || overflow_o !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got busy=%b done=%b ovf=%b expected 0/0/0", busy_o, done_o, overflow_o);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_aligned;
    logic [P*W-1:0] exp;
    out_ready_i = 1'b1;
    do_start(4);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL aligned_busy: got %b expected 1", busy_o); end
    fork
      drive_stream(4, 16, 0);
      begin
        int cyc, got, first;
        cyc = 0; got = 0; first = 0;
        while (got < 4 && cyc < 200) begin
          @(negedge clk); cyc++;
          if (out_valid_o && first == 0) begin
            first = cyc;
            checks++; if (first !== 3) begin errors++; $display("FAIL aligned_latency: got %0d expected 3", first); end
          end
          if (out_valid_o && out_ready_i) begin
            exp = (sb.size() > 0) ? sb.pop_front() : '0;
            checks++; if (out_data_o !== exp) begin errors++; $display("FAIL aligned_vec%0d: got %h expected %h", got, out_data_o, exp); end
            got++;
          end
        end
        checks++; if (got !== 4) begin errors++; $display("FAIL aligned_count: got %0d expected 4", got); end
      end
    join
    @(negedge clk);
    checks++; if (done_o !== 1'b1 || busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
      errors++; $display("FAIL aligned_done: got done=%b busy=%b valid=%b expected 1/0/0", done_o, busy_o, out_valid_o);
    end
    @(negedge clk);
    checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL aligned_done_pulse: got done=%b busy=%b expected 0/0", done_o, busy_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_skewed;
    logic [P*W-1:0] exp;
    out_ready_i = 1'b1;
    do_start(3);
    fork
      drive_stream(3, 100, 1);
      begin
        int cyc, got, first;
        cyc = 0; got = 0; first = 0;
        while (got < 3 && cyc < 300) begin
          @(negedge clk); cyc++;
          if (out_valid_o && first == 0) begin
            first = cyc;
            checks++; if (first !== 3 + (P-1)) begin errors++; $display("FAIL skew_latency: got %0d expected %0d", first, 3 + (P-1)); end
          end
          if (out_valid_o && out_ready_i) begin
            exp = (sb.size() > 0) ? sb.pop_front() : '0;
            checks++; if (out_data_o !== exp) begin errors++; $display("FAIL skew_vec%0d: got %h expected %h", got, out_data_o, exp); end
            got++;
          end
        end
        checks++; if (got !== 3) begin errors++; $display("FAIL skew_count: got %0d expected 3", got); end
      end
    join
    @(negedge clk);
    checks++; if (done_o !== 1'b1 || overflow_o !== 1'b0) begin
      errors++; $display("FAIL skew_done: got done=%b ovf=%b expected 1/0", done_o, overflow_o);
    end
    @(negedge clk);
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL skew_done_pulse: got %b expected 0", done_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    logic [P*W-1:0] exp;
    bit bp_run;
    bp_run = 1'b1;
    out_ready_i = 1'b1;
    do_start(8);
    fork
      drive_stream(8, 1000, 0);
      begin
        for (int c = 0; c < 400 && bp_run; c++) begin
          out_ready_i = ~out_ready_i;
          @(posedge clk); #1;
        end
      end
      begin
        int cyc, got;
        bit prev_stall;
        logic [P*W-1:0] prev_data;
        cyc = 0; got = 0; prev_stall = 1'b0; prev_data = '0;
        while (got < 8 && cyc < 300) begin
          @(negedge clk); cyc++;
          if (prev_stall) begin
            checks++; if (out_valid_o !== 1'b1 || out_data_o !== prev_data) begin
              errors++; $display("FAIL bp_hold: got valid=%b data=%h expected 1 %h", out_valid_o, out_data_o, prev_data);
            end
          end
          prev_stall = out_valid_o && !out_ready_i;
          prev_data  = out_data_o;
          if (out_valid_o && out_ready_i) begin
            exp = (sb.size() > 0) ? sb.pop_front() : '0;
            checks++; if (out_data_o !== exp) begin errors++; $display("FAIL bp_vec%0d: got %h expected %h", got, out_data_o, exp); end
            got++;
          end
        end
        bp_run = 1'b0;
        checks++; if (got !== 8) begin errors++; $display("FAIL bp_count: got %0d expected 8", got); end
      end
    join
    out_ready_i = 1'b1;
    @(negedge clk);
    checks++; if (done_o !== 1'b1 || overflow_o !== 1'b0) begin
      errors++; $display("FAIL bp_done: got done=%b ovf=%b expected 1/0", done_o, overflow_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow;
    logic [P*W-1:0] exp;
    int cyc, got;
    out_ready_i = 1'b0;
    do_start(1);
    for (int w = 0; w < 17; w++) begin
      psum_en_row_i    = '0;
      psum_en_row_i[3] = 1'b1;
      psum_row_i[W*(P-1-3) +: W] = W'(500 + w);
      @(posedge clk); #1;
      if (w == 15) begin
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_at16: got %b expected 0", overflow_o); end
      end
      if (w == 16) begin
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_at17: got %b expected 1", overflow_o); end
      end
    end
    psum_en_row_i = '0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow_o); end
    // Complete the job: the other lanes catch up, lane 3 head is its first value
    exp = '0;
    for (int i = 0; i < P; i++) begin
      if (i != 3) begin
        psum_en_row_i[i] = 1'b1;
        psum_row_i[W*(P-1-i) +: W] = W'(900 + i);
        exp[W*(P-1-i) +: W] = W'(900 + i);
      end else begin
        exp[W*(P-1-i) +: W] = W'(500);
      end
    end
    sb.push_back(exp);
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    psum_en_row_i = '0;
    cyc = 0; got = 0;
    while (got < 1 && cyc < 20) begin
      @(negedge clk); cyc++;
      if (out_valid_o && out_ready_i) begin
        exp = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++; if (out_data_o !== exp) begin errors++; $display("FAIL ovf_vec: got %h expected %h", out_data_o, exp); end
        got++;
      end
    end
    checks++; if (got !== 1) begin errors++; $display("FAIL ovf_count: got %0d expected 1", got); end
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (busy_o !== 1'b0 || overflow_o !== 1'b1) begin
      errors++; $display("FAIL ovf_idle: got busy=%b ovf=%b expected 0/1", busy_o, overflow_o);
    end
    do_start(1);
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow_o); end
    // Leftover lane-3 entries must be gone after the new start
    exp = '0;
    for (int i = 0; i < P; i++) begin
      psum_en_row_i[i] = 1'b1;
      psum_row_i[W*(P-1-i) +: W] = W'(7000 + i);
      exp[W*(P-1-i) +: W] = W'(7000 + i);
    end
    sb.push_back(exp);
    @(posedge clk); #1;
    psum_en_row_i = '0;
    cyc = 0; got = 0;
    while (got < 1 && cyc < 20) begin
      @(negedge clk); cyc++;
      if (out_valid_o && out_ready_i) begin
        exp = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++; if (out_data_o !== exp) begin errors++; $display("FAIL leftover_vec: got %h expected %h", out_data_o, exp); end
        got++;
      end
    end
    checks++; if (got !== 1) begin errors++; $display("FAIL leftover_count: got %0d expected 1", got); end
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic test_zero_abort;
    logic [P*W-1:0] exp;
    out_ready_i = 1'b1;
    do_start(0);
    @(negedge clk);
    checks++; if (done_o !== 1'b1 || out_valid_o !== 1'b0) begin
      errors++; $display("FAIL zero_done: got done=%b valid=%b expected 1/0", done_o, out_valid_o);
    end
    @(negedge clk);
    checks++; if (done_o !== 1'b0 || out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL zero_after: got done=%b valid=%b busy=%b expected 0/0/0", done_o, out_valid_o, busy_o);
    end
    @(posedge clk); #1;
    do_start(5);
    fork
      drive_stream(5, 16, 0);
      begin
        int cyc, got;
        cyc = 0; got = 0;
        while (got < 2 && cyc < 100) begin
          @(negedge clk); cyc++;
          if (out_valid_o && out_ready_i) begin
            exp = (sb.size() > 0) ? sb.pop_front() : '0;
            checks++; if (out_data_o !== exp) begin errors++; $display("FAIL abort_vec%0d: got %h expected %h", got, out_data_o, exp); end
            got++;
          end
        end
        checks++; if (got !== 2) begin errors++; $display("FAIL abort_count: got %0d expected 2", got); end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_data_o !== '0 || out_valid_o !== 1'b0) begin
          errors++; $display("FAIL abort_out: got valid=%b data=%h expected 0", out_valid_o, out_data_o);
        end
        checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || overflow_o !== 1'b0) begin
          errors++; $display("FAIL abort_flags: got busy=%b done=%b ovf=%b expected 0/0/0", busy_o, done_o, overflow_o);
        end
      end
    join
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_relu;
    logic [P*W-1:0] exp;
    int cyc, got;
    out_ready_i = 1'b1;
    do_start(1);
    exp = '0;
    for (int i = 0; i < P; i++) begin
      psum_en_row_i[i] = 1'b1;
      psum_row_i[W*(P-1-i) +: W] = W'(20 + i);
      exp[W*(P-1-i) +: W] = W'(20 + i);
    end
    psum_row_i[W*(P-1) +: W] = 32'hFFFF_FFF6;
    psum_row_i[W*(P-2) +: W] = 32'd7;
`ifdef PSUM_RELU_EN
    exp[W*(P-1) +: W] = 32'd0;
`else
    exp[W*(P-1) +: W] = 32'hFFFF_FFF6;
`endif
    exp[W*(P-2) +: W] = 32'd7;
    sb.push_back(exp);
    @(posedge clk); #1;
    psum_en_row_i = '0;
    cyc = 0; got = 0;
    while (got < 1 && cyc < 20) begin
      @(negedge clk); cyc++;
      if (out_valid_o && out_ready_i) begin
        exp = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++; if (out_data_o !== exp) begin errors++; $display("FAIL relu_vec: got %h expected %h", out_data_o, exp); end
        got++;
      end
    end
    checks++; if (got !== 1) begin errors++; $display("FAIL relu_count: got %0d expected 1", got); end
    repeat (4) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_aligned();
    test_skewed();
    test_backpressure();
    test_overflow();
    test_zero_abort();
    test_relu();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sa_psum_collector.md
Name: sa_psum_collector

Overview:
Receive-side companion of the systolic array (SA). Captures the skewed per-row partial-sum stream (psum_row_o / psum_en_row_o of SA) into per-row FIFOs and de-skews it. Emits row-aligned PE_SIZE-lane result vectors to the output buffer over a valid/ready handshake. Counts emitted vectors against a programmed total and signals completion.

Parameters:
PE_SIZE, 16, number of SA rows (lanes)
PSUM_WIDTH, 32, bits per partial sum
DEPTH, 16, entries per row FIFO (power of 2, >=2)
CNT_W, 16, width of vector counter / num_vec_i

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start_i  in  1  pulse: begin a collection job
num_vec_i  in  CNT_W  vectors to emit; sampled on start_i
psum_row_i  in  PSUM_WIDTH*PE_SIZE  psums from SA; lane i at [PSUM_WIDTH*(PE_SIZE-i)-1 : PSUM_WIDTH*(PE_SIZE-i-1)]
psum_en_row_i  in  PE_SIZE  per-lane valid, bit i = lane i
out_data_o  out  PSUM_WIDTH*PE_SIZE  aligned vector, same lane packing
out_valid_o  out  1  out_data_o valid
out_ready_i  in  1  downstream accepts
busy_o  out  1  high in COLLECT
done_o  out  1  one-cycle pulse at job end
overflow_o  out  1  sticky: a lane write was dropped

Behaviour:
- Reset (async, rst_n=0): state IDLE, FIFOs empty, counter 0; out_data_o=0, out_valid_o=0, busy_o=0, done_o=0, overflow_o=0. Reset mid-job aborts immediately; no partial output.
- FSM: IDLE -> COLLECT on start_i; COLLECT -> DONE when the emitted count reaches the latched num_vec; DONE -> IDLE unconditionally after 1 cycle.
- start_i with num_vec_i=0: IDLE -> DONE directly; done_o pulses on the next cycle; nothing is emitted.
- start_i in IDLE: clears all FIFOs, the output register and overflow_o; latches num_vec_i; resets the counter. start_i outside IDLE is ignored.
- psum_en_row_i is ignored outside COLLECT.
- Lane write in COLLECT: psum_en_row_i[i]=1 writes lane i data into FIFO i.
- FIFO i full with no pop in the same cycle: the write is dropped and overflow_o sets (sticky until next start_i).
- Full FIFO with a simultaneous pop: the write is accepted.
- Output register: loads when every FIFO is non-empty AND (out_valid_o=0 OR out_ready_i=1) AND the vectors already emitted plus the one in flight are fewer than num_vec. A load pops one entry from every FIFO at that edge.
- Latency: last lane's entry written at edge N -> out_valid_o=1 after edge N+1.
- Hold rule: while out_valid_o=1 and out_ready_i=0, out_data_o and out_valid_o hold stable.
- Throughput: one vector per cycle under continuous ready.
- Handshake: out_valid_o & out_ready_i increments the counter. If no new load occurs in that cycle, out_valid_o drops.
- Completion: when the counter reaches num_vec, next state is DONE; done_o=1 for exactly that one DONE cycle; busy_o=0 from DONE onward.
- Leftovers: FIFO entries remaining at job end persist until the next start_i clears them.
- Arithmetic: data passes unmodified; counter is CNT_W bits, num_vec <= 2^CNT_W-1, no wrap within a job.
- Skew tolerance: lane i may lead lane j by up to DEPTH entries without loss.

Optional Feature:
PSUM_RELU_EN: when defined, each lane is clamped at the output-register load: negative (MSB=1) signed psums become 0, non-negative pass unchanged. Undefined: data passes raw. Affects only out_data_o; counts, handshake and timing are identical either way.

Test Plan:
- Aligned stream: start num_vec=4; all lanes en for 4 cycles, lane i value = 16*k+i on cycle k -> 4 vectors, vector k lane i = 16*k+i; out_valid 1 cycle after first write; done_o pulses once; busy_o low afterwards.
- Skewed stream: lane i starts writing i cycles after lane 0 (SA diagonal), num_vec=3, values = 100*k+i -> first out_valid after lane 15's first write +1 cycle; vectors correctly aligned; no overflow.
- Backpressure: num_vec=8, out_ready_i toggles 1/0 every cycle, aligned writes -> out_data_o stable while stalled; 8 handshakes; no loss for DEPTH=16.
- Overflow: DEPTH=16, lane 3 writes 17 values with out_ready_i=0 (other lanes idle) -> overflow_o=1 after 17th write, stays 1; cleared by next start_i.
- Zero/abort: start with num_vec=0 -> done_o 1 cycle later, out_valid_o never 1. Then start num_vec=5, assert rst_n=0 after 2 vectors -> all outputs 0 immediately.
- PSUM_RELU_EN defined: lane 0 = 32'hFFFF_FFF6 (-10), lane 1 = 7 -> lane 0 out 0, lane 1 out 7; undefined -> lane 0 out 32'hFFFF_FFF6.
